// File: rtl/title_scroll_ctrl.sv
// title_scroll_ctrl
// Sequences one line of the 12-slot title text renderer. A title of up to
// MAX_LEN character ROM base addresses is loaded into a small buffer. Titles
// that fit are shown left-aligned with blank padding. Longer titles scroll
// left one slot per step, dwelling at both ends. Slots only change on
// frame_tick so the picture never tears mid-frame.
//
// Ports:
//   clk        system/pixel clock
//   rst        synchronous, active-high reset
//   frame_tick one-cycle pulse per video frame (start of vertical blank)
//   load_start discard the current title and begin loading a new one
//   char_valid append char_data to the buffer (LOAD only)
//   char_data  ROM base address of the character being appended
//   load_done  commit the loaded length and start display
//   chars      packed slot addresses, slot 0 (leftmost) = bits [8:0]
//   busy       high while loading
//   scrolling  high while in HOLD_START, SCROLL or HOLD_END
//   overflow   sticky: a character was dropped because the buffer was full
module title_scroll_ctrl #(
    parameter int unsigned MAX_LEN     = 32,
    parameter int unsigned SLOTS       = 12,
    parameter int unsigned HOLD_FRAMES = 60,
    parameter int unsigned STEP_FRAMES = 15,
    parameter logic [8:0]  BLANK_ADDR  = 9'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_tick,
    input  logic                 load_start,
    input  logic                 char_valid,
    input  logic [8:0]           char_data,
    input  logic                 load_done,
    output logic [SLOTS*9-1:0]   chars,
    output logic                 busy,
    output logic                 scrolling,
    output logic                 overflow
);

    localparam int unsigned CW   = 9;
    localparam int unsigned PW   = $clog2(MAX_LEN + 1);
    localparam int unsigned PW1  = PW + 1;
    localparam int unsigned AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned FMAX = (HOLD_FRAMES > STEP_FRAMES) ? HOLD_FRAMES : STEP_FRAMES;
    localparam int unsigned FW   = (FMAX > 1) ? $clog2(FMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STATIC,
        S_HOLD_START,
        S_SCROLL,
        S_HOLD_END
    } state_t;

    state_t               state_q;
    logic [PW-1:0]        wr_ptr_q;
    logic [PW-1:0]        len_q;
    logic [PW-1:0]        offset_q;
    logic [FW-1:0]        fcnt_q;
    logic [SLOTS*CW-1:0]  chars_q;
    logic [CW-1:0]        buf_mem [MAX_LEN];

    logic                 char_accept;
    logic                 char_drop;
    logic [PW-1:0]        commit_len;
    logic                 show;
    logic [SLOTS*CW-1:0]  slot_next;
    logic                 hold_last;
    logic                 step_last;
    logic [PW-1:0]        offset_inc;
    logic [PW-1:0]        offset_max;

    // load_start takes priority over any write or commit in the same cycle
    assign char_accept = (state_q == S_LOAD) && !load_start && char_valid
                         && (wr_ptr_q < PW'(MAX_LEN));
    assign char_drop   = (state_q == S_LOAD) && !load_start && char_valid
                         && (wr_ptr_q == PW'(MAX_LEN));

    // Committed length includes a character accepted alongside load_done
    assign commit_len  = wr_ptr_q + PW'(char_accept);

    assign show        = (state_q != S_IDLE) && (state_q != S_LOAD);
    assign hold_last   = (fcnt_q == FW'(HOLD_FRAMES - 1));
    assign step_last   = (fcnt_q == FW'(STEP_FRAMES - 1));
    assign offset_inc  = offset_q + PW'(1);
    assign offset_max  = len_q - PW'(SLOTS);

    // Title buffer: not reset, only written by accepted characters
    always_ff @(posedge clk) begin
        if (!rst && char_accept) begin
            buf_mem[AW'(wr_ptr_q)] <= char_data;
        end
    end

    // Per-slot source: one bit wider than offset so the length compare never wraps
    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        logic [PW1-1:0] pos;
        logic           in_range;
        assign pos      = PW1'(offset_q) + PW1'(g);
        assign in_range = show && (pos < PW1'(len_q));
        assign slot_next[g*CW +: CW] = in_range ? buf_mem[pos[AW-1:0]] : BLANK_ADDR;
    end

    // Control FSM with registered outputs; slots sample pre-update state on a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            len_q     <= '0;
            offset_q  <= '0;
            fcnt_q    <= '0;
            chars_q   <= {SLOTS{BLANK_ADDR}};
            busy      <= 1'b0;
            scrolling <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (frame_tick) begin
                chars_q <= slot_next;
            end

            if (load_start) begin
                state_q   <= S_LOAD;
                wr_ptr_q  <= '0;
                offset_q  <= '0;
                fcnt_q    <= '0;
                overflow  <= 1'b0;
                busy      <= 1'b1;
                scrolling <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (char_accept) begin
                            wr_ptr_q <= wr_ptr_q + PW'(1);
                        end
                        if (char_drop) begin
                            overflow <= 1'b1;
                        end
                        if (load_done) begin
                            len_q <= commit_len;
                            busy  <= 1'b0;
                            if (commit_len == '0) begin
                                state_q <= S_IDLE;
                            end else if (commit_len <= PW'(SLOTS)) begin
                                state_q <= S_STATIC;
                            end else begin
                                state_q   <= S_HOLD_START;
                                offset_q  <= '0;
                                fcnt_q    <= '0;
                                scrolling <= 1'b1;
                            end
                        end
                    end

                    S_HOLD_START: begin
                        if (frame_tick) begin
                            if (hold_last) begin
                                fcnt_q  <= '0;
                                state_q <= S_SCROLL;
                            end else begin
                                fcnt_q <= fcnt_q + FW'(1);
                            end
                        end
                    end

                    S_SCROLL: begin
                        if (frame_tick) begin
                            if (step_last) begin
                                fcnt_q   <= '0;
                                offset_q <= offset_inc;
                                if (offset_inc == offset_max) begin
                                    state_q <= S_HOLD_END;
                                end
                            end else begin
                                fcnt_q <= fcnt_q + FW'(1);
                            end
                        end
                    end

                    S_HOLD_END: begin
                        if (frame_tick) begin
                            if (hold_last) begin
                                fcnt_q   <= '0;
                                offset_q <= '0;
                                state_q  <= S_HOLD_START;
                            end else begin
                                fcnt_q <= fcnt_q + FW'(1);
                            end
                        end
                    end

                    default: begin
                        // IDLE and STATIC: no counting, window pinned at the start
                        offset_q <= '0;
                        fcnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign chars = chars_q;

endmodule

// File: tb/tb_title_scroll_ctrl.sv
// Directed bench for title_scroll_ctrl with short dwell/step timings.
module tb_title_scroll_ctrl;

    localparam int unsigned SLOTS = 12;

    logic                clk;
    logic                rst;
    logic                frame_tick;
    logic                load_start;
    logic                char_valid;
    logic [8:0]          char_data;
    logic                load_done;
    logic [SLOTS*9-1:0]  chars;
    logic                busy;
    logic                scrolling;
    logic                overflow;

    int n_tests;
    int n_fail;

    title_scroll_ctrl #(
        .MAX_LEN    (32),
        .SLOTS      (SLOTS),
        .HOLD_FRAMES(2),
        .STEP_FRAMES(1),
        .BLANK_ADDR (9'd0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .load_start(load_start),
        .char_valid(char_valid),
        .char_data (char_data),
        .load_done (load_done),
        .chars     (chars),
        .busy      (busy),
        .scrolling (scrolling),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    function automatic logic [8:0] slot(input int i);
        return chars[i*9 +: 9];
    endfunction

    task automatic begin_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
    endtask

    task automatic push_chars(input logic [8:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            char_valid = 1'b1;
            char_data  = base + 9'(k);
            step();
        end
        char_valid = 1'b0;
    endtask

    task automatic commit();
        load_done = 1'b1;
        step();
        load_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            frame_tick = (c == 0);
            step();
        end
        frame_tick = 1'b0;
        rst = 1'b0;
        n_tests++;
        if (chars !== '0) begin
            n_fail++;
            $display("FAIL reset_chars got=%h want=0", chars);
        end
        n_tests++;
        if ({busy, scrolling, overflow} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got=%b want=000", {busy, scrolling, overflow});
        end
    endtask

    task automatic test_static();
        logic [SLOTS*9-1:0] exp;
        exp = '0;
        for (int i = 0; i < 5; i++) exp[i*9 +: 9] = 9'h10 + 9'(i);
        begin_load();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL static_busy got=%b want=1", busy);
        end
        push_chars(9'h10, 5);
        commit();
        n_tests++;
        if ({busy, scrolling} !== 2'b00) begin
            n_fail++;
            $display("FAIL static_flags got=%b want=00", {busy, scrolling});
        end
        tick();
        for (int i = 0; i < SLOTS; i++) begin
            n_tests++;
            if (slot(i) !== exp[i*9 +: 9]) begin
                n_fail++;
                $display("FAIL static_slot%0d got=%h want=%h", i, slot(i), exp[i*9 +: 9]);
            end
        end
        for (int t = 0; t < 20; t++) tick();
        n_tests++;
        if (chars !== exp || scrolling !== 1'b0) begin
            n_fail++;
            $display("FAIL static_hold got=%h scr=%b want=%h scr=0", chars, scrolling, exp);
        end
    endtask

    task automatic test_scroll();
        logic [8:0] exp0 [7];
        exp0 = '{9'h20, 9'h20, 9'h20, 9'h21, 9'h22, 9'h22, 9'h20};
        begin_load();
        push_chars(9'h20, 14);
        commit();
        n_tests++;
        if (scrolling !== 1'b1) begin
            n_fail++;
            $display("FAIL scroll_flag got=%b want=1", scrolling);
        end
        for (int t = 1; t <= 7; t++) begin
            tick();
            n_tests++;
            if (slot(0) !== exp0[t-1]) begin
                n_fail++;
                $display("FAIL scroll_tick%0d_slot0 got=%h want=%h", t, slot(0), exp0[t-1]);
            end
            if (t == 1) begin
                n_tests++;
                if (slot(11) !== 9'h2B) begin
                    n_fail++;
                    $display("FAIL scroll_tick1_slot11 got=%h want=2b", slot(11));
                end
            end
            if (t == 5) begin
                n_tests++;
                if (slot(11) !== 9'h2D) begin
                    n_fail++;
                    $display("FAIL scroll_tick5_slot11 got=%h want=2d", slot(11));
                end
            end
        end
    endtask

    task automatic test_overflow();
        begin_load();
        push_chars(9'h40, 32);
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_at_full got=%b want=0", overflow);
        end
        push_chars(9'h60, 3);
        n_tests++;
        if (overflow !== 1'b1 || dut.wr_ptr_q !== 6'd32) begin
            n_fail++;
            $display("FAIL ovf_set got=%b ptr=%0d want=1 ptr=32", overflow, dut.wr_ptr_q);
        end
        commit();
        n_tests++;
        if (dut.len_q !== 6'd32 || scrolling !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_len got=%0d scr=%b want=32 scr=1", dut.len_q, scrolling);
        end
        tick();
        n_tests++;
        if (slot(0) !== 9'h40 || slot(11) !== 9'h4B) begin
            n_fail++;
            $display("FAIL ovf_slots got=%h,%h want=40,4b", slot(0), slot(11));
        end
        begin_load();
        n_tests++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_clear got=%b busy=%b want=0 busy=1", overflow, busy);
        end
    endtask

    task automatic test_simultaneous();
        // 13th char accepted in the same cycle as load_done
        begin_load();
        push_chars(9'h30, 12);
        char_valid = 1'b1;
        char_data  = 9'h3C;
        commit();
        char_valid = 1'b0;
        n_tests++;
        if (dut.len_q !== 6'd13 || scrolling !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_len13 got=%0d scr=%b want=13 scr=1", dut.len_q, scrolling);
        end
        tick();
        n_tests++;
        if (slot(0) !== 9'h30 || slot(11) !== 9'h3B) begin
            n_fail++;
            $display("FAIL sim_len13_slots got=%h,%h want=30,3b", slot(0), slot(11));
        end
        // char_valid with load_start is ignored
        char_valid = 1'b1;
        char_data  = 9'h1FF;
        begin_load();
        char_valid = 1'b0;
        n_tests++;
        if (dut.wr_ptr_q !== 6'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sim_start_char got=%0d busy=%b want=0 busy=1", dut.wr_ptr_q, busy);
        end
        push_chars(9'h45, 1);
        commit();
        n_tests++;
        if (dut.len_q !== 6'd1 || scrolling !== 1'b0) begin
            n_fail++;
            $display("FAIL sim_len1 got=%0d scr=%b want=1 scr=0", dut.len_q, scrolling);
        end
        tick();
        n_tests++;
        if (slot(0) !== 9'h45 || slot(1) !== 9'h0) begin
            n_fail++;
            $display("FAIL sim_len1_slots got=%h,%h want=45,0", slot(0), slot(1));
        end
        // frame_tick together with load_done sees the LOAD state
        begin_load();
        push_chars(9'h50, 2);
        frame_tick = 1'b1;
        commit();
        frame_tick = 1'b0;
        n_tests++;
        if (chars !== '0) begin
            n_fail++;
            $display("FAIL sim_tick_done got=%h want=0", chars);
        end
        tick();
        n_tests++;
        if (slot(0) !== 9'h50 || slot(1) !== 9'h51 || slot(2) !== 9'h0) begin
            n_fail++;
            $display("FAIL sim_tick_next got=%h,%h,%h want=50,51,0", slot(0), slot(1), slot(2));
        end
    endtask

    task automatic test_restart_mid_scroll();
        begin_load();
        push_chars(9'h20, 14);
        commit();
        tick();
        tick();
        begin_load();
        n_tests++;
        if (scrolling !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_flags got scr=%b busy=%b want scr=0 busy=1", scrolling, busy);
        end
        tick();
        n_tests++;
        if (chars !== '0) begin
            n_fail++;
            $display("FAIL restart_blank got=%h want=0", chars);
        end
    endtask

    task automatic test_reset_mid_scroll();
        begin_load();
        push_chars(9'h20, 14);
        commit();
        tick();
        tick();
        tick();
        n_tests++;
        if (dut.offset_q !== 6'd1 || scrolling !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre got off=%0d scr=%b want off=1 scr=1", dut.offset_q, scrolling);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (chars !== '0 || scrolling !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_post got=%h scr=%b busy=%b want=0 scr=0 busy=0", chars, scrolling, busy);
        end
        for (int t = 0; t < 3; t++) tick();
        n_tests++;
        if (chars !== '0 || scrolling !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ticks got=%h scr=%b want=0 scr=0", chars, scrolling);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        frame_tick = 1'b0;
        load_start = 1'b0;
        char_valid = 1'b0;
        char_data  = 9'h0;
        load_done  = 1'b0;
        test_reset();
        test_static();
        test_scroll();
        test_overflow();
        test_simultaneous();
        test_restart_mid_scroll();
        test_reset_mid_scroll();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/title_scroll_ctrl.md
Name: title_scroll_ctrl

Overview:
- Sequences the 12-slot title text renderer: holds a title of up to MAX_LEN characters and drives the 12 per-slot character ROM base addresses.
- Titles of 12 characters or fewer are shown statically, left-aligned, with blank padding.
- Longer titles scroll left one slot at a time, with dwell periods at both ends.
- Slot contents change only on frame_tick, so the picture never tears mid-frame; one instance is used per title line (song, instrument).

Parameters:
- MAX_LEN, 32: character buffer depth; maximum title length.
- SLOTS, 12: number of displayed character slots.
- HOLD_FRAMES, 60: frames to dwell at the start and at the end of a scroll pass (≥1).
- STEP_FRAMES, 15: frames between single-slot scroll steps (≥1).
- BLANK_ADDR, 9'd0: ROM base address of the space glyph.

Ports:
- clk  in  1  system/pixel clock.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame (start of vertical blank).
- load_start  in  1  pulse: discard the current title and begin loading a new one.
- char_valid  in  1  append char_data to the buffer this cycle (LOAD state only).
- char_data  in  9  ROM base address of the character being appended.
- load_done  in  1  pulse: commit the loaded length and start display.
- chars  out  SLOTS*9  packed slot addresses; slot 0 = bits [8:0], the leftmost slot.
- busy  out  1  high while in LOAD.
- scrolling  out  1  high in HOLD_START, SCROLL and HOLD_END.
- overflow  out  1  sticky: a character was dropped because the buffer was full.

Behaviour:
- Reset (synchronous, active-high, wins over all inputs): state=IDLE, len=0, wr_ptr=0, offset=0, fcnt=0, every slot=BLANK_ADDR, busy=0, scrolling=0, overflow=0. The buffer RAM is not reset.
- States: IDLE, LOAD, STATIC, HOLD_START, SCROLL, HOLD_END.
- load_start, from any state:
  - Next state LOAD; wr_ptr=0, overflow=0, offset=0, fcnt=0.
  - A char_valid or load_done in the same cycle is ignored.
- LOAD:
  - char_valid with wr_ptr<MAX_LEN: buf[wr_ptr]=char_data, wr_ptr++.
  - char_valid with wr_ptr==MAX_LEN: character dropped, overflow=1.
  - load_done: len = wr_ptr, including any char_valid accepted in the same cycle. Then:
    - len==0: go to IDLE.
    - len≤SLOTS: go to STATIC.
    - otherwise: go to HOLD_START with offset=0, fcnt=0.
- load_done outside LOAD: ignored. char_valid outside LOAD: ignored.
- fcnt advances only on frame_tick, and only in HOLD_START, SCROLL and HOLD_END.
- HOLD_START: on a tick with fcnt==HOLD_FRAMES-1, set fcnt=0 and go to SCROLL; otherwise fcnt++ on each tick.
- SCROLL: on a tick with fcnt==STEP_FRAMES-1, set fcnt=0 and offset++. If the new offset equals len-SLOTS, go to HOLD_END. Otherwise fcnt++ on each tick.
- HOLD_END: on a tick with fcnt==HOLD_FRAMES-1, set fcnt=0, offset=0 and go to HOLD_START.
- STATIC and IDLE: offset stays 0; no counting.
- Slot update, on frame_tick only:
  - slot[i] = buf[offset+i] if the state is not IDLE/LOAD and offset+i<len; otherwise BLANK_ADDR.
  - Uses the registered offset from before that cycle's update, so a scroll step appears at the following tick (one-frame latency).
  - chars is otherwise held constant between ticks.
- Consequences of the update rule:
  - In LOAD and IDLE, all slots blank at the next tick.
  - Committing a new title shows it at the first tick after load_done.
- frame_tick in the same cycle as load_done: the slot update uses the pre-commit state (LOAD), so the slots go blank; the title appears at the following tick.
- Width rules:
  - offset and wr_ptr are clog2(MAX_LEN+1) bits.
  - offset+i is computed one bit wider, so the comparison with len never wraps.
- Max offset = len-SLOTS, which never exceeds MAX_LEN-SLOTS.
- load_start mid-scroll: scrolling drops the next cycle and the slots blank at the next tick.

Test Plan:
- Reset: assert rst for 2 cycles with frame_tick toggling.
  -> all 12 slots = 0; busy, scrolling and overflow = 0; state IDLE.
- Static title, HOLD_FRAMES=2, STEP_FRAMES=1: load 5 chars 9'h10..9'h14, then load_done, then one tick.
  -> slots 0-4 = 10..14, slots 5-11 = 0; scrolling=0; chars unchanged after 20 further ticks.
- Scroll pass: load 14 chars 9'h20..9'h2D; count ticks after commit.
  - Tick 1: slot0 = 20.
  - Slot0 = 21 first appears at tick 4, then 22 at tick 5.
  - HOLD_END is entered with offset=2; slot0 stays 22 for 2 ticks, then returns to 20.
- Overflow: load 35 chars.
  -> wr_ptr=32, overflow=1, len=32.
  -> the next load_start clears overflow in the following cycle.
- Simultaneous events:
  - char_valid with load_done on the 13th char -> len=13 and scrolling begins.
  - load_start together with char_valid -> the char is not written and wr_ptr=0.
  - frame_tick with load_done -> slots blank at that tick; the title appears at the next tick.
- Reset mid-scroll: assert rst while in SCROLL with offset=1.
  -> the next cycle shows IDLE, all slots = 0 and scrolling=0; frame_ticks leave chars at 0.
